// File: rtl/bus_trace_capture.sv
// CPU bus tracer: records qualified bus cycles (sampled on CLK_en) into a first-word-fall-through FIFO.
// Push lands on the qualifying edge (valid one cycle later); a full FIFO drops the entry and sets OVERFLOW unless a pop coincides.
module bus_trace_capture #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter logic [ADDR_W-1:0] TRAP_ADDR = ADDR_W'('hFFFC)
) (
  input  logic                       CLK,
  input  logic                       nRESET,
  input  logic                       CLK_en,
  input  logic [ADDR_W-1:0]          Address_bus,
  input  logic [DATA_W-1:0]          Data_bus,
  input  logic                       RnW,
  input  logic                       SYNC,
  input  logic                       ARM,
  input  logic                       STOP,
  input  logic [1:0]                 MODE,
  input  logic                       trace_ready,
  output logic                       trace_valid,
  output logic [ADDR_W-1:0]          trace_addr,
  output logic [DATA_W-1:0]          trace_data,
  output logic                       trace_rnw,
  output logic                       trace_sync,
  output logic [$clog2(DEPTH+1)-1:0] trace_count,
  output logic                       OVERFLOW,
  output logic                       TRAP,
  output logic [1:0]                 STATE
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              rnw;
    logic              sync;
  } entry_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_HALTED  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  entry_t        mem [DEPTH];
  entry_t        head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          overflow, trap;
  logic          mode_hit, qual, trap_hit, pop, full, push_ok;

  // ARM and STOP both suppress capture of the coincident bus cycle.
  always_comb begin
    mode_hit = 1'b0;
    case (MODE)
      2'd0:    mode_hit = !RnW;
      2'd1:    mode_hit = !RnW || SYNC;
      default: mode_hit = 1'b1;
    endcase
    qual     = (state == S_CAPTURE) && CLK_en && mode_hit && !STOP && !ARM;
    trap_hit = qual && !RnW && (Address_bus == TRAP_ADDR);
    pop      = (count != '0) && trace_ready;
    full     = (count == CW'(DEPTH));
    push_ok  = qual && (!full || pop);
  end

  always_comb begin
    state_nxt = state;
    if (ARM) begin
      state_nxt = S_CAPTURE;
    end else begin
      case (state)
        S_CAPTURE: begin
          if (STOP)          state_nxt = S_IDLE;
          else if (trap_hit) state_nxt = S_HALTED;
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      trap     <= 1'b0;
    end else if (ARM) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      trap     <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (qual && full && !pop) overflow <= 1'b1;
      if (trap_hit)             trap     <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr] <= '{addr: Address_bus, data: Data_bus, rnw: RnW, sync: SYNC};
  end

  // Head is masked when empty so stale RAM never leaks out after reset or flush.
  assign head        = (count != '0) ? mem[rd_ptr] : '0;
  assign trace_valid = (count != '0);
  assign trace_addr  = head.addr;
  assign trace_data  = head.data;
  assign trace_rnw   = head.rnw;
  assign trace_sync  = head.sync;
  assign trace_count = count;
  assign OVERFLOW    = overflow;
  assign TRAP        = trap;
  assign STATE       = state;

endmodule

// File: tb/tb_bus_trace_capture.sv
// Bench for bus_trace_capture: directed scenarios plus random traffic against a queue-based reference model.
module tb_bus_trace_capture;

  localparam int DEPTH = 16;

  logic        CLK = 1'b0;
  logic        nRESET;
  logic        CLK_en;
  logic [15:0] Address_bus;
  logic [7:0]  Data_bus;
  logic        RnW, SYNC, ARM, STOP;
  logic [1:0]  MODE;
  logic        trace_ready;
  logic        trace_valid, trace_rnw, trace_sync, OVERFLOW, TRAP;
  logic [15:0] trace_addr;
  logic [7:0]  trace_data;
  logic [4:0]  trace_count;
  logic [1:0]  STATE;

  bus_trace_capture #(.ADDR_W(16), .DATA_W(8), .DEPTH(DEPTH), .TRAP_ADDR(16'hFFFC)) dut (
    .CLK(CLK), .nRESET(nRESET), .CLK_en(CLK_en), .Address_bus(Address_bus),
    .Data_bus(Data_bus), .RnW(RnW), .SYNC(SYNC), .ARM(ARM), .STOP(STOP),
    .MODE(MODE), .trace_ready(trace_ready), .trace_valid(trace_valid),
    .trace_addr(trace_addr), .trace_data(trace_data), .trace_rnw(trace_rnw),
    .trace_sync(trace_sync), .trace_count(trace_count), .OVERFLOW(OVERFLOW),
    .TRAP(TRAP), .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
    logic        r;
    logic        s;
  } ent_t;

  ent_t q[$];
  int   m_state;
  bit   m_ovf, m_trap;
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_state = 0;
    m_ovf   = 0;
    m_trap  = 0;
  endtask

  // Reference behaviour for one CLK edge, from the inputs present at that edge.
  task automatic model_step();
    bit want, qual, popped;
    popped = (q.size() != 0) && trace_ready;
    if (ARM) begin
      q.delete();
      m_ovf = 0; m_trap = 0; m_state = 1;
    end else begin
      want = (MODE == 0) ? !RnW : (MODE == 1) ? (!RnW || SYNC) : 1'b1;
      qual = (m_state == 1) && CLK_en && want && !STOP;
      if (popped) void'(q.pop_front());
      if (qual) begin
        if (q.size() < DEPTH) q.push_back('{a: Address_bus, d: Data_bus, r: RnW, s: SYNC});
        else m_ovf = 1;
      end
      if (m_state == 1 && STOP) m_state = 0;
      else if (qual && !RnW && Address_bus == 16'hFFFC) begin
        m_state = 2; m_trap = 1;
      end
    end
  endtask

  task automatic check_all();
    ent_t h;
    h = (q.size() != 0) ? q[0] : '0;
    check_val("valid", trace_valid, q.size() != 0);
    check_val("count", trace_count, q.size());
    check_val("addr",  trace_addr,  h.a);
    check_val("data",  trace_data,  h.d);
    check_val("rnw",   trace_rnw,   h.r);
    check_val("sync",  trace_sync,  h.s);
    check_val("ovf",   OVERFLOW,    m_ovf);
    check_val("trap",  TRAP,        m_trap);
    check_val("state", STATE,       m_state);
  endtask

  task automatic drive(input logic en, input logic [15:0] ad, input logic [7:0] d,
                       input logic r, input logic s, input logic ar, input logic sp,
                       input logic rdy);
    CLK_en = en; Address_bus = ad; Data_bus = d; RnW = r; SYNC = s;
    ARM = ar; STOP = sp; trace_ready = rdy;
    @(posedge CLK);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle(input logic rdy);
    drive(0, 16'h0000, 8'h00, 1, 0, 0, 0, rdy);
  endtask

  task automatic arm();
    drive(0, 16'h0000, 8'h00, 1, 0, 1, 0, 0);
  endtask

  // Called just after an edge; reset is applied and released between edges.
  task automatic async_reset();
    nRESET = 1'b0;
    #1;
    model_reset();
    check_val("rst_valid", trace_valid, 0);
    check_val("rst_count", trace_count, 0);
    check_val("rst_ovf",   OVERFLOW,    0);
    check_val("rst_state", STATE,       0);
    check_val("rst_addr",  trace_addr,  0);
    check_all();
    #2;
    nRESET = 1'b1;
  endtask

  logic [15:0] t1_a [3];
  logic [7:0]  t1_d [3];
  int          rprob;

  initial begin
    nRESET = 1'b0; CLK_en = 0; Address_bus = 0; Data_bus = 0; RnW = 1; SYNC = 0;
    ARM = 0; STOP = 0; MODE = 0; trace_ready = 0;
    model_reset();
    #2;
    check_all();
    #10;
    nRESET = 1'b1;
    idle(0);

    // Writes-only capture with interleaved reads.
    MODE = 0;
    arm();
    t1_a = '{16'h0200, 16'h0201, 16'h0300};
    t1_d = '{8'h11, 8'h22, 8'h33};
    drive(1, 16'h0200, 8'h11, 0, 0, 0, 0, 0);
    drive(1, 16'h1000, 8'hEE, 1, 0, 0, 0, 0);
    drive(1, 16'h0201, 8'h22, 0, 0, 0, 0, 0);
    drive(1, 16'h1001, 8'hDD, 1, 0, 0, 0, 0);
    drive(1, 16'h0300, 8'h33, 0, 0, 0, 0, 0);
    check_val("t1_count", trace_count, 3);
    for (int i = 0; i < 3; i++) begin
      check_val("t1_addr", trace_addr, t1_a[i]);
      check_val("t1_data", trace_data, t1_d[i]);
      check_val("t1_rnw",  trace_rnw,  0);
      idle(1);
    end
    check_val("t1_empty", trace_valid, 0);

    // Writes plus opcode fetches.
    MODE = 1;
    arm();
    drive(1, 16'hC000, 8'hA9, 1, 1, 0, 0, 0);
    drive(1, 16'hC001, 8'h01, 1, 0, 0, 0, 0);
    drive(1, 16'h0010, 8'h55, 0, 0, 0, 0, 0);
    check_val("t2_count", trace_count, 2);
    check_val("t2_a0", trace_addr, 16'hC000);
    check_val("t2_s0", trace_sync, 1);
    idle(1);
    check_val("t2_a1", trace_addr, 16'h0010);
    check_val("t2_d1", trace_data, 8'h55);
    idle(1);

    // Overflow, then full with a coincident pop.
    MODE = 2;
    arm();
    for (int i = 0; i < 20; i++) drive(1, 16'h0100 + 16'(i), 8'(i), 1, 0, 0, 0, 0);
    check_val("t3_count", trace_count, DEPTH);
    check_val("t3_ovf",   OVERFLOW, 1);
    check_val("t3_head",  trace_addr, 16'h0100);
    arm();
    for (int i = 0; i < 16; i++) drive(1, 16'h0100 + 16'(i), 8'(i), 1, 0, 0, 0, 0);
    drive(1, 16'h0110, 8'h10, 1, 0, 0, 0, 1);
    check_val("t3b_count", trace_count, DEPTH);
    check_val("t3b_ovf",   OVERFLOW, 0);
    check_val("t3b_head",  trace_addr, 16'h0101);

    // Trap write halts capture.
    MODE = 0;
    arm();
    drive(1, 16'hFFFC, 8'h00, 0, 0, 0, 0, 0);
    check_val("t4_trap",  TRAP, 1);
    check_val("t4_state", STATE, 2);
    check_val("t4_count", trace_count, 1);
    drive(1, 16'h0400, 8'h44, 0, 0, 0, 0, 0);
    check_val("t4_nocap", trace_count, 1);
    drive(0, 16'h0000, 8'h00, 1, 0, 0, 1, 0);
    check_val("t4_stopign", STATE, 2);
    arm();
    check_val("t4_rearm", STATE, 1);
    check_val("t4_clr",   TRAP, 0);

    // ARM beats STOP; STOP alone idles the tracer.
    drive(0, 16'h0000, 8'h00, 1, 0, 0, 1, 0);
    drive(0, 16'h0000, 8'h00, 1, 0, 1, 1, 0);
    check_val("t5_armwin", STATE, 1);
    drive(0, 16'h0000, 8'h00, 1, 0, 0, 1, 0);
    check_val("t5_stop", STATE, 0);
    drive(1, 16'h0500, 8'h66, 0, 0, 0, 0, 0);
    drive(1, 16'h0501, 8'h67, 0, 0, 0, 0, 0);
    check_val("t5_count", trace_count, 0);

    // Asynchronous reset with live contents.
    MODE = 2;
    arm();
    for (int i = 0; i < 17; i++) drive(1, 16'h0600 + 16'(i), 8'(i), 1, 0, 0, 0, 0);
    for (int i = 0; i < 11; i++) idle(1);
    check_val("t6_count", trace_count, 5);
    check_val("t6_ovf",   OVERFLOW, 1);
    async_reset();

    // Random traffic.
    rprob = 50;
    for (int n = 0; n < 3000; n++) begin
      logic [15:0] ad;
      if ($urandom_range(0, 99) == 0) begin
        MODE  = 2'($urandom_range(0, 3));
        rprob = $urandom_range(0, 100);
      end
      if ($urandom_range(0, 499) == 0) async_reset();
      ad = ($urandom_range(0, 7) == 0) ? 16'hFFFC : 16'($urandom_range(0, 16'hFFFF));
      drive($urandom_range(0, 3) != 0, ad, 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 49) == 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 99) < rprob);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_trace_capture.md
Name: bus_trace_capture

Overview:
Synthesizable, parametrised CPU bus tracer that sits alongside the MOS6502 bus and records qualified bus cycles into an on-chip FIFO for readout by a debug host. Generalises write-checking and stop-on-reset-vector-write into hardware: selectable capture mode, configurable depth and widths, a programmable trap address that halts capture, and sticky overflow reporting. Samples only on CLK_en strobes, so it runs in the CPU clock domain with no extra clocking.

Parameters:
ADDR_W, 16, address bus width
DATA_W, 8, data bus width
DEPTH, 16, FIFO entries; power of two, >= 2
TRAP_ADDR, 16'hFFFC, write to this address raises TRAP and halts capture

Ports:
CLK  in  1  system clock
nRESET  in  1  asynchronous active-low reset
CLK_en  in  1  CPU cycle strobe; bus is sampled only when high
Address_bus  in  ADDR_W  CPU address
Data_bus  in  DATA_W  CPU data (read or write value)
RnW  in  1  1 = read, 0 = write
SYNC  in  1  opcode fetch cycle
ARM  in  1  single-cycle pulse: clear and start capture
STOP  in  1  single-cycle pulse: stop capture
MODE  in  2  0 = writes only, 1 = writes + SYNC fetches, 2/3 = all cycles
trace_ready  in  1  host pop request
trace_valid  out  1  FIFO non-empty (first-word fall-through)
trace_addr  out  ADDR_W  head entry address
trace_data  out  DATA_W  head entry data
trace_rnw  out  1  head entry RnW
trace_sync  out  1  head entry SYNC
trace_count  out  $clog2(DEPTH+1)  entries held
OVERFLOW  out  1  sticky: a qualified cycle was dropped
TRAP  out  1  sticky: trap write seen
STATE  out  2  0 = IDLE, 1 = CAPTURE, 2 = HALTED

Behaviour:
- Reset (async, nRESET low): STATE=IDLE, FIFO empty, trace_valid=0, trace_count=0, OVERFLOW=0, TRAP=0, trace_addr/data/rnw/sync=0.
- Qualified cycle: STATE=CAPTURE and CLK_en=1 and (MODE0: RnW=0; MODE1: RnW=0 or SYNC=1; MODE2/3: always).
- Push: a qualified cycle writes {Address_bus, Data_bus, RnW, SYNC} on that CLK edge; trace_valid rises the following cycle when the FIFO was empty (1-cycle latency).
- Pop: trace_valid and trace_ready on an edge advances the head; trace_ready with trace_valid=0 is ignored. Popping is allowed in every state.
- Full: push with count=DEPTH and no same-cycle pop drops the entry and sets OVERFLOW. Push and pop on the same edge when full both succeed; count stays DEPTH and OVERFLOW is not set.
- Simultaneous push and pop when empty: push only.
- Pointers wrap modulo DEPTH. count = pushes - pops, saturating at 0 and at DEPTH.
- FSM:
  - IDLE --ARM--> CAPTURE.
  - CAPTURE --STOP--> IDLE.
  - CAPTURE --qualified write (RnW=0, CLK_en=1) with Address_bus==TRAP_ADDR--> HALTED; TRAP=1. The trap write is itself pushed (subject to full rules).
  - HALTED --ARM--> CAPTURE. HALTED ignores STOP.
- ARM, in any state: flushes the FIFO (count=0, trace_valid=0 next cycle), clears OVERFLOW and TRAP, enters CAPTURE. The CLK_en cycle coincident with ARM is not captured.
- ARM and STOP on the same edge: ARM wins.
- STOP coincident with a qualified cycle: the cycle is not captured.
- A trap write in MODE0, 1 or 2 always triggers.
- nRESET asserted mid-capture: everything returns to reset values immediately; FIFO contents are lost.

Test Plan:
- Reset, ARM, MODE=0; three CLK_en writes ($0200=$11, $0201=$22, $0300=$33) plus two reads -> count=3; pops return exactly those entries in order with rnw=0; trace_valid falls after the third pop.
- MODE=1; SYNC fetch at $C000 with data $A9, then read $C001, then write $0010=$55 -> exactly two entries: ($C000,$A9,rnw=1,sync=1) and ($0010,$55,rnw=0,sync=0).
- DEPTH=16, MODE=2, no pops, 20 qualified cycles -> count=16, OVERFLOW=1, entries are the first 16. Repeat the 17th push with a same-edge pop -> accepted, OVERFLOW remains 0 after a fresh ARM.
- Write $FFFC=$00 in CAPTURE -> TRAP=1, STATE=2, entry captured; later writes are not recorded; STOP ignored; ARM -> STATE=1, count=0, TRAP=0.
- ARM and STOP pulsed together from IDLE -> STATE=1. STOP alone -> STATE=0; subsequent CLK_en writes leave count unchanged.
- Assert nRESET with count=5 and OVERFLOW=1 -> all outputs zero asynchronously, before the next CLK edge.
